// File: rtl/riscv_mem_pkg.sv
// Shared definitions for the instruction-memory slice.
//   ADDR_W / XLEN : address and instruction word widths
//   INSTR_NOP     : word returned on error responses (addi x0,x0,0)
//   instr_resp_t  : one read response, {data, err}
package riscv_mem_pkg;

    localparam int ADDR_W = 32;
    localparam int XLEN   = 32;

    localparam logic [XLEN-1:0] INSTR_NOP = 32'h0000_0013;

    typedef struct packed {
        logic [XLEN-1:0] data;
        logic            err;
    } instr_resp_t;

endpackage

// File: rtl/resp_delay_line.sv
// Fixed-latency, in-order response pipeline for the instruction responder.
// A response entering stage 0 at edge k is presented on the outputs during
// the cycle after edge k+LATENCY-1.
//   clk_i        : clock
//   rst_ni       : asynchronous active-low clear (drops every in-flight entry)
//   in_valid_i   : a response is entered this edge
//   in_resp_i    : {data, err} of the entered response
//   out_valid_o  : response valid (one cycle per entry)
//   out_data_o   : response data, holds the last returned value when idle
//   out_err_o    : response error, forced low when out_valid_o is low
module resp_delay_line
    import riscv_mem_pkg::*;
#(
    parameter int LATENCY = 1
) (
    input  logic            clk_i,
    input  logic            rst_ni,
    input  logic            in_valid_i,
    input  instr_resp_t     in_resp_i,
    output logic            out_valid_o,
    output logic [XLEN-1:0] out_data_o,
    output logic            out_err_o
);

    logic        valid_q [LATENCY];
    instr_resp_t resp_q  [LATENCY];

    // Payload only advances behind a valid entry, so the final stage keeps
    // the last returned word while the line is idle.
    // NOTE: state registers use non-blocking assignments so every stage
    // samples its predecessor's pre-edge value, giving a true shift.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            for (int i = 0; i < LATENCY; i++) begin
                valid_q[i] <= 1'b0;
                resp_q[i]  <= '0;
            end
        end else begin
            valid_q[0] <= in_valid_i;
            if (in_valid_i) begin
                resp_q[0] <= in_resp_i;
            end
            for (int i = 1; i < LATENCY; i++) begin
                valid_q[i] <= valid_q[i-1];
                if (valid_q[i-1]) begin
                    resp_q[i] <= resp_q[i-1];
                end
            end
        end
    end

    assign out_valid_o = valid_q[LATENCY-1];
    assign out_data_o  = resp_q[LATENCY-1].data;
    assign out_err_o   = valid_q[LATENCY-1] & resp_q[LATENCY-1].err;

endmodule

// File: rtl/instr_mem_responder.sv
// Instruction-memory responder: memory side of the fetch req/gnt/rvalid
// interface, with a loader write port for program preload.
//   req              : clock, rising edge
//   reset            : asynchronous active-low reset
//   instr_req_in     : fetch request valid
//   instr_addr_in    : fetch byte address
//   stall_in         : backpressure, withholds grant
//   gnt_out          : request granted this cycle (combinational)
//   instr_rvalid_out : response valid
//   instr_rdata_out  : response word (holds while rvalid is low)
//   instr_err_out    : misaligned / out-of-range response, qualified by rvalid
//   load_we_in       : loader write enable
//   load_addr_in     : loader byte address (word aligned)
//   load_data_in     : loader write data
module instr_mem_responder
    import riscv_mem_pkg::*;
#(
    parameter int DEPTH_WORDS     = 1024,
    parameter int LATENCY         = 1,
    parameter int MAX_OUTSTANDING = 2
) (
    input  logic              req,
    input  logic              reset,
    input  logic              instr_req_in,
    input  logic [ADDR_W-1:0] instr_addr_in,
    input  logic              stall_in,
    output logic              gnt_out,
    output logic              instr_rvalid_out,
    output logic [XLEN-1:0]   instr_rdata_out,
    output logic              instr_err_out,
    input  logic              load_we_in,
    input  logic [ADDR_W-1:0] load_addr_in,
    input  logic [XLEN-1:0]   load_data_in
);

    localparam int IDX_W = (DEPTH_WORDS > 1) ? $clog2(DEPTH_WORDS) : 1;
    localparam int CNT_W = 3;

    // Full throughput needs MAX_OUTSTANDING >= LATENCY; smaller values are
    // legal and simply insert bubbles.
    if (LATENCY < 1 || LATENCY > 4) begin : g_bad_latency
        $error("instr_mem_responder: LATENCY must be within 1..4");
    end
    if (MAX_OUTSTANDING < 1 || MAX_OUTSTANDING > 4) begin : g_bad_outstanding
        $error("instr_mem_responder: MAX_OUTSTANDING must be within 1..4");
    end

    logic [ADDR_W-3:0] rd_word;
    logic [ADDR_W-3:0] ld_word;
    logic              rd_in_range;
    logic              ld_in_range;
    logic              load_addr_unused;
    logic              accept;
    logic              retire;
    logic [CNT_W-1:0]  count_q;
    logic [CNT_W-1:0]  count_d;
    instr_resp_t       rd_resp;
    logic [XLEN-1:0]   mem_q [DEPTH_WORDS];

    assign rd_word     = instr_addr_in[ADDR_W-1:2];
    assign ld_word     = load_addr_in[ADDR_W-1:2];
    assign rd_in_range = (rd_word < (ADDR_W-2)'(DEPTH_WORDS));
    assign ld_in_range = (ld_word < (ADDR_W-2)'(DEPTH_WORDS));

    // Loader addresses are word aligned; their byte-offset bits carry nothing.
    assign load_addr_unused = ^load_addr_in[1:0];

    // NOTE: the store has no reset on purpose -- its contents survive reset
    // and a reset loop over the array would cost a write port per word.
    always_ff @(posedge req) begin
        if (load_we_in && ld_in_range) begin
            mem_q[ld_word[IDX_W-1:0]] <= load_data_in;
        end
    end

    // The read is sampled into the delay line at the acceptance edge, so a
    // same-edge loader write to that word is not yet visible (old data).
    // NOTE: every output of this block gets a default first, so no path
    // leaves it unassigned and no latch is inferred.
    always_comb begin
        rd_resp.data = INSTR_NOP;
        rd_resp.err  = 1'b1;
        if (rd_in_range && (instr_addr_in[1:0] == 2'b00)) begin
            rd_resp.data = mem_q[rd_word[IDX_W-1:0]];
            rd_resp.err  = 1'b0;
        end
    end

    // A retiring response frees its slot on the same edge, so a full
    // responder can still grant in the rvalid cycle.
    assign retire  = instr_rvalid_out;
    assign gnt_out = reset & instr_req_in & ~stall_in &
                     ((count_q < CNT_W'(MAX_OUTSTANDING)) | retire);
    assign accept  = instr_req_in & gnt_out;

    always_comb begin
        count_d = count_q;
        case ({accept, retire})
            2'b10:   count_d = count_q + CNT_W'(1);
            2'b01:   count_d = count_q - CNT_W'(1);
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge req or negedge reset) begin
        if (!reset) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    resp_delay_line #(
        .LATENCY (LATENCY)
    ) u_resp_delay_line (
        .clk_i       (req),
        .rst_ni      (reset),
        .in_valid_i  (accept),
        .in_resp_i   (rd_resp),
        .out_valid_o (instr_rvalid_out),
        .out_data_o  (instr_rdata_out),
        .out_err_o   (instr_err_out)
    );

endmodule

// File: tb/tb_instr_mem_responder.sv
// Bench for instr_mem_responder. Two instances run side by side: dut0 with
// LATENCY=1 and dut1 with LATENCY=3, both MAX_OUTSTANDING=2. A reference
// model (queue of pending responses tagged with the cycle they are due)
// checks every output of both instances every cycle; directed steps add
// spot checks of the documented scenarios, followed by a random phase.
module tb_instr_mem_responder;

    localparam int          DEPTH = 1024;
    localparam int          MAXO  = 2;
    localparam logic [31:0] NOP   = 32'h0000_0013;
    localparam logic [31:0] W0    = 32'h0010_8093;
    localparam logic [31:0] W1    = 32'h0031_8193;

    typedef struct packed {
        logic [31:0] data;
        logic        err;
        int          due;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [1:0]  req;
    logic [1:0]  stall;
    logic [1:0]  load_we;
    logic [31:0] addr      [2];
    logic [31:0] load_addr [2];
    logic [31:0] load_data [2];
    wire  [1:0]  gnt;
    wire  [1:0]  rvalid;
    wire  [1:0]  err;
    wire  [31:0] rdata     [2];

    int          checks = 0;
    int          errors = 0;
    int          cyc    = 0;
    exp_t        pend    [2][$];
    logic [31:0] mem_m   [2][DEPTH];
    logic [31:0] last_rd [2];
    logic        gnt_seen [2];

    always #5 clk = ~clk;

    instr_mem_responder #(
        .DEPTH_WORDS(DEPTH), .LATENCY(1), .MAX_OUTSTANDING(MAXO)
    ) dut0 (
        .req(clk), .reset(rst_n),
        .instr_req_in(req[0]), .instr_addr_in(addr[0]), .stall_in(stall[0]),
        .gnt_out(gnt[0]), .instr_rvalid_out(rvalid[0]),
        .instr_rdata_out(rdata[0]), .instr_err_out(err[0]),
        .load_we_in(load_we[0]), .load_addr_in(load_addr[0]),
        .load_data_in(load_data[0])
    );

    instr_mem_responder #(
        .DEPTH_WORDS(DEPTH), .LATENCY(3), .MAX_OUTSTANDING(MAXO)
    ) dut1 (
        .req(clk), .reset(rst_n),
        .instr_req_in(req[1]), .instr_addr_in(addr[1]), .stall_in(stall[1]),
        .gnt_out(gnt[1]), .instr_rvalid_out(rvalid[1]),
        .instr_rdata_out(rdata[1]), .instr_err_out(err[1]),
        .load_we_in(load_we[1]), .load_addr_in(load_addr[1]),
        .load_data_in(load_data[1])
    );

    function automatic int lat_of(input int id);
        return (id == 0) ? 1 : 3;
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s (cycle %0d): observed %h expected %h", tag, cyc, obs, exp);
        end
    endtask

    // Called mid-cycle: compare this cycle's outputs, then advance the model
    // to what the coming edge does.
    task automatic model_cycle(input int id);
        logic        exp_rv;
        logic [31:0] exp_rd;
        logic        exp_er;
        logic        exp_g;
        logic [29:0] widx;
        exp_t        e;
        gnt_seen[id] = gnt[id];
        if (!rst_n) begin
            pend[id].delete();
            last_rd[id] = 32'h0;
            exp_rv = 1'b0;
            exp_rd = 32'h0;
            exp_er = 1'b0;
            exp_g  = 1'b0;
        end else begin
            exp_rv = (pend[id].size() > 0) && (pend[id][0].due == cyc);
            exp_rd = exp_rv ? pend[id][0].data : last_rd[id];
            exp_er = exp_rv && pend[id][0].err;
            exp_g  = req[id] && !stall[id] && ((pend[id].size() < MAXO) || exp_rv);
        end
        check($sformatf("rvalid%0d", id), 32'(rvalid[id]), 32'(exp_rv));
        check($sformatf("rdata%0d", id), rdata[id], exp_rd);
        check($sformatf("err%0d", id), 32'(err[id]), 32'(exp_er));
        check($sformatf("gnt%0d", id), 32'(gnt[id]), 32'(exp_g));
        if (rst_n) begin
            if (exp_rv) begin
                last_rd[id] = pend[id][0].data;
                void'(pend[id].pop_front());
            end
            if (exp_g) begin
                widx  = addr[id][31:2];
                e.due = cyc + lat_of(id);
                if ((addr[id][1:0] != 2'b00) || (widx >= 30'(DEPTH))) begin
                    e.data = NOP;
                    e.err  = 1'b1;
                end else begin
                    e.data = mem_m[id][widx];
                    e.err  = 1'b0;
                end
                pend[id].push_back(e);
            end
            if (load_we[id] && (load_addr[id][31:2] < 30'(DEPTH))) begin
                mem_m[id][load_addr[id][31:2]] = load_data[id];
            end
        end
    endtask

    // One clock cycle; returns 1 time unit after the next rising edge.
    task automatic tick();
        @(negedge clk);
        for (int id = 0; id < 2; id++) model_cycle(id);
        @(posedge clk);
        #1;
        cyc++;
    endtask

    task automatic load_word(input int idx, input logic [31:0] d);
        for (int id = 0; id < 2; id++) begin
            load_we[id]   = 1'b1;
            load_addr[id] = 32'(idx) << 2;
            load_data[id] = d;
        end
        tick();
        load_we = '0;
    endtask

    // Hold the current request until the DUT grants it (bounded).
    task automatic wait_gnt(input int id, output int gcyc);
        gcyc = -1;
        for (int w = 0; w < 16; w++) begin
            gcyc = cyc;
            tick();
            if (gnt_seen[id]) break;
        end
        check($sformatf("gnt_wait%0d", id), 32'(gnt_seen[id]), 32'd1);
    endtask

    initial begin
        int g0, g1, g2, sel, word;
        rst_n   = 1'b1;
        req     = '0;
        stall   = '0;
        load_we = '0;
        for (int i = 0; i < 2; i++) begin
            addr[i]      = '0;
            load_addr[i] = '0;
            load_data[i] = '0;
            last_rd[i]   = '0;
            gnt_seen[i]  = 1'b0;
        end
        #1 rst_n = 1'b0;
        repeat (2) tick();

        check("rst_rvalid", 32'(rvalid), 32'd0);
        check("rst_err",    32'(err),    32'd0);
        check("rst_rdata0", rdata[0],    32'h0);
        check("rst_rdata1", rdata[1],    32'h0);
        rst_n = 1'b1;

        load_word(0, W0);
        load_word(1, W1);
        for (int i = 2; i < 64; i++) load_word(i, $urandom());

        // Back-to-back reads, LATENCY=1.
        req[0] = 1'b1; addr[0] = 32'h0;
        tick();
        check("b2b_gnt0", 32'(gnt_seen[0]), 32'd1);
        check("b2b_rd0",  rdata[0], W0);
        check("b2b_rv0",  32'(rvalid[0]), 32'd1);
        addr[0] = 32'h4;
        tick();
        check("b2b_gnt1", 32'(gnt_seen[0]), 32'd1);
        check("b2b_rd1",  rdata[0], W1);
        check("b2b_err1", 32'(err[0]), 32'd0);
        req[0] = 1'b0;
        tick();
        check("idle_rv",   32'(rvalid[0]), 32'd0);
        check("rd_hold",   rdata[0], W1);

        // Misaligned, then aligned read.
        req[0] = 1'b1; addr[0] = 32'h2;
        tick();
        req[0] = 1'b0;
        check("mis_rd",  rdata[0], NOP);
        check("mis_err", 32'(err[0]), 32'd1);
        req[0] = 1'b1; addr[0] = 32'h0;
        tick();
        req[0] = 1'b0;
        check("aln_rd",  rdata[0], W0);
        check("aln_err", 32'(err[0]), 32'd0);

        // Out of range.
        req[0] = 1'b1; addr[0] = 32'(DEPTH * 4);
        tick();
        req[0] = 1'b0;
        check("oor_rd",  rdata[0], NOP);
        check("oor_err", 32'(err[0]), 32'd1);
        tick();

        // Backpressure.
        req[0] = 1'b1; stall[0] = 1'b1; addr[0] = 32'h4;
        repeat (3) begin
            tick();
            check("stall_gnt", 32'(gnt_seen[0]), 32'd0);
            check("stall_rv",  32'(rvalid[0]), 32'd0);
        end
        stall[0] = 1'b0;
        tick();
        req[0] = 1'b0;
        check("unstall_gnt", 32'(gnt_seen[0]), 32'd1);
        check("unstall_rv",  32'(rvalid[0]), 32'd1);
        check("unstall_rd",  rdata[0], W1);
        tick();

        // Outstanding limit on the LATENCY=3 instance.
        req[1] = 1'b1; addr[1] = 32'h0;
        wait_gnt(1, g0);
        addr[1] = 32'h4;
        wait_gnt(1, g1);
        addr[1] = 32'h8;
        wait_gnt(1, g2);
        req[1] = 1'b0;
        check("lim_gap1", 32'(g1 - g0), 32'd1);
        check("lim_gap2", 32'(g2 - g0), 32'd3);
        repeat (6) tick();

        // Reset with two requests accepted and unreturned.
        req[1] = 1'b1; addr[1] = 32'h0;
        wait_gnt(1, g0);
        addr[1] = 32'h4;
        wait_gnt(1, g1);
        req[1] = 1'b0;
        tick();
        check("pre_rst_rv", 32'(rvalid[1]), 32'd1);
        #2 rst_n = 1'b0;
        req[0] = 1'b1; addr[0] = 32'h0;
        #1;
        check("async_rv",  32'(rvalid[1]), 32'd0);
        check("rst_count", 32'(dut1.count_q), 32'd0);
        tick();
        rst_n  = 1'b1;
        req[0] = 1'b0;
        repeat (6) tick();
        req[1] = 1'b1; addr[1] = 32'h0;
        wait_gnt(1, g0);
        req[1] = 1'b0;
        repeat (2) tick();
        check("reread_rv", 32'(rvalid[1]), 32'd1);
        check("reread_rd", rdata[1], W0);
        repeat (2) tick();

        // Random traffic on both instances.
        for (int n = 0; n < 600; n++) begin
            for (int id = 0; id < 2; id++) begin
                req[id]   = ($urandom_range(0, 3) != 0);
                stall[id] = ($urandom_range(0, 4) == 0);
                sel       = int'($urandom_range(0, 9));
                word      = int'($urandom_range(0, 63));
                if (sel == 0)
                    addr[id] = (32'(word) << 2) + 32'($urandom_range(1, 3));
                else if (sel == 1)
                    addr[id] = 32'(DEPTH * 4) + (32'(word) << 2);
                else
                    addr[id] = 32'(word) << 2;
                word          = int'($urandom_range(0, 63));
                load_we[id]   = ($urandom_range(0, 5) == 0);
                load_addr[id] = ($urandom_range(0, 3) == 0) ?
                                32'(DEPTH * 4) + (32'(word) << 2) : (32'(word) << 2);
                load_data[id] = $urandom();
            end
            tick();
        end
        req     = '0;
        load_we = '0;
        stall   = '0;
        repeat (8) tick();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/instr_mem_responder.md
Name: instr_mem_responder

Overview:
- Instruction-memory responder: the memory end of the fetch stage's req/gnt/rvalid instruction interface.
- Accepts fetch requests, grants them subject to backpressure and an outstanding-request limit, and returns in-order read data after a fixed latency.
- Used in benches and in the SoC top as the instruction ROM. It also has a loader write port for program preload.

Parameters:
- DEPTH_WORDS, 1024, number of 32-bit words in the instruction store.
- LATENCY, 1, cycles from acceptance edge to the rvalid cycle; legal range 1..4.
- MAX_OUTSTANDING, 2, maximum accepted-but-unreturned requests; legal range 1..4.

Ports:
- req  in  1  clock (codebase clock name), rising edge active.
- reset  in  1  asynchronous, active-low reset.
- instr_req_in  in  1  fetch request valid.
- instr_addr_in  in  32  byte address of the requested instruction.
- stall_in  in  1  backpressure; 1 withholds grant.
- gnt_out  out  1  request granted this cycle.
- instr_rvalid_out  out  1  response valid.
- instr_rdata_out  out  32  response instruction word.
- instr_err_out  out  1  response error (misaligned or out of range), qualified by rvalid.
- load_we_in  in  1  loader write enable.
- load_addr_in  in  32  loader byte address (word aligned).
- load_data_in  in  32  loader write data.

Behaviour:
- Clock and reset: one clock, req. Reset is asynchronous and active-low.
- Reset values: instr_rvalid_out=0, instr_rdata_out=32'h0, instr_err_out=0, outstanding count=0. gnt_out is forced 0 while reset is low.
- Reset effects: in-flight responses are discarded. Memory contents are not cleared.
- Reset mid-operation: rvalid drops immediately (async). No stale response appears after reset releases.
- Grant (combinational): gnt_out = instr_req_in & ~stall_in & (count < MAX_OUTSTANDING | retire_now).
  - retire_now = instr_rvalid_out is high this cycle.
- Accept: at a posedge with instr_req_in & gnt_out.
  - Word index = instr_addr_in[31:2].
  - The store is read at the acceptance edge. The response {data, err} enters delay stage 0.
- Latency: a request accepted at edge k drives instr_rvalid_out high during the cycle after edge k+LATENCY-1.
  - Example: LATENCY=1 gives rvalid in the cycle immediately after the grant cycle.
  - rvalid lasts exactly one cycle per request.
- Ordering and throughput: responses are returned strictly in order. Back-to-back accepts give back-to-back responses.
- Outstanding count:
  - +1 on accept, -1 on retire (edge ending an rvalid cycle).
  - Simultaneous accept and retire leaves the count unchanged.
  - The count never exceeds MAX_OUTSTANDING.
  - Full throughput requires MAX_OUTSTANDING >= LATENCY.
- Error responses: if instr_addr_in[1:0] != 0 or the word index >= DEPTH_WORDS, the response is rdata=32'h0000_0013 (NOP, addi x0,x0,0) with err=1.
- Read data hold: instr_rdata_out holds its last value when rvalid is low. instr_err_out is 0 when rvalid is low.
- Loader:
  - Writes the word at load_addr_in[31:2] on the posedge when load_we_in=1.
  - Out-of-range loader writes are ignored.
  - A loader write and an accepted read to the same word on the same edge: the read returns the old data.
- Parameter checks: elaboration-time assertion on the LATENCY and MAX_OUTSTANDING ranges.

Decomposition:
- Shared package (riscv_mem_pkg):
  - INSTR_NOP = 32'h0000_0013.
  - ADDR_W = 32, XLEN = 32.
  - typedef instr_resp_t {logic [31:0] data; logic err;}.
- Sub-module resp_delay_line: a LATENCY-stage shift register of {valid, instr_resp_t} with an async active-low clear. It produces the rvalid/rdata/err outputs.
- Top level: store array, grant logic, outstanding counter, loader port.

Test Plan:
- Back-to-back read, LATENCY=1:
  - Stimulus: reset, load word0=32'h00108093 and word1=32'h00318193, then request addr 0x0 and 0x4 on consecutive cycles.
  - Response: gnt high in both cycles. rvalid in the next two cycles with 00108093 then 00318193, err=0.
- Outstanding limit, LATENCY=3, MAX_OUTSTANDING=2:
  - Stimulus: instr_req_in held high for requests to 0x0, 0x4, 0x8.
  - Response: the first two are granted in consecutive cycles. The third is granted only in the cycle the 0x0 response returns. Data returns in order.
- Misaligned address:
  - Stimulus: request addr 0x2.
  - Response: one rvalid cycle with rdata=32'h00000013 and err=1. The following aligned read has err=0.
- Out-of-range address:
  - Stimulus: request addr 4*DEPTH_WORDS (0x1000 at the default depth).
  - Response: rdata=32'h00000013, err=1.
- Backpressure:
  - Stimulus: stall_in=1 with instr_req_in=1 for 3 cycles, then stall_in=0.
  - Response: gnt=0 and no rvalid while stalled. Grant occurs in the first unstalled cycle, with rvalid the next cycle.
- Reset mid-operation:
  - Stimulus: reset pulled low with 2 requests in flight.
  - Response: rvalid drops to 0 asynchronously and count returns to 0. After release, no stale rvalid appears, and re-reading word0 returns 32'h00108093 (memory retained).
